// File: rtl/ecc_serial_host_pkg.sv
// Shared definitions for the ECC serial host: mode/state encodings, default
// word width and the mode-to-width helper.
package ecc_serial_host_pkg;

  localparam int unsigned MAX_BITS_DEFAULT = 128;

  typedef enum logic [1:0] {
    BITS16  = 2'b00,
    BITS32  = 2'b01,
    BITS64  = 2'b10,
    BITS128 = 2'b11
  } mode_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_MODE  = 3'd2,
    ST_SEND  = 3'd3,
    ST_WAIT  = 3'd4,
    ST_RECV  = 3'd5,
    ST_DONE  = 3'd6
  } state_e;

  // Index of the most significant active bit (N-1) for a width mode.
  function automatic logic [6:0] mode_last(input logic [1:0] mode);
    case (mode_e'(mode))
      BITS16:  return 7'd15;
      BITS32:  return 7'd31;
      BITS64:  return 7'd63;
      default: return 7'd127;
    endcase
  endfunction

endpackage

// File: rtl/ecc_serial_host_if.sv
// Bus-side command/result handshake plus the wrapper's serial pins.
// The host uses the slave modport; the job issuer/wrapper side uses master.
interface ecc_serial_host_if #(
  parameter int unsigned MAX_BITS = ecc_serial_host_pkg::MAX_BITS_DEFAULT
);
  logic                cmd_valid;
  logic                cmd_ready;
  logic [1:0]          cmd_mode;
  logic [MAX_BITS-1:0] cmd_a;
  logic [MAX_BITS-1:0] cmd_prime;
  logic [MAX_BITS-1:0] cmd_px;
  logic [MAX_BITS-1:0] cmd_py;
  logic [MAX_BITS-1:0] cmd_mul;
  logic                res_valid;
  logic                res_ready;
  logic [MAX_BITS-1:0] res_x;
  logic [MAX_BITS-1:0] res_y;
  logic                res_err;
  logic                busy;
  logic                s_data_valid;
  logic                s_mode;
  logic                s_a;
  logic                s_prime;
  logic                s_px;
  logic                s_py;
  logic                s_mul;
  logic                s_res_valid;
  logic                s_res_x;
  logic                s_res_y;

  modport slave (
    input  cmd_valid, cmd_mode, cmd_a, cmd_prime, cmd_px, cmd_py, cmd_mul,
    input  res_ready, s_res_valid, s_res_x, s_res_y,
    output cmd_ready, res_valid, res_x, res_y, res_err, busy,
    output s_data_valid, s_mode, s_a, s_prime, s_px, s_py, s_mul
  );

  modport master (
    output cmd_valid, cmd_mode, cmd_a, cmd_prime, cmd_px, cmd_py, cmd_mul,
    output res_ready, s_res_valid, s_res_x, s_res_y,
    input  cmd_ready, res_valid, res_x, res_y, res_err, busy,
    input  s_data_valid, s_mode, s_a, s_prime, s_px, s_py, s_mul
  );

endinterface

// File: rtl/ecc_serial_host_piso_shreg.sv
// Loadable MSB-first parallel-in/serial-out shift register (module ecc_piso_shreg).
// The serial tap is bit N-1 of the selected mode; output bit is registered.
module ecc_piso_shreg
  import ecc_serial_host_pkg::*;
#(
  parameter int unsigned MAX_BITS = MAX_BITS_DEFAULT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load_i,
  input  logic                shift_i,
  input  logic [1:0]          mode_i,
  input  logic [MAX_BITS-1:0] data_i,
  output logic                bit_o
);

  logic [MAX_BITS-1:0] data_q;
  logic                bit_q;
  logic [6:0]          tap;

  assign tap   = mode_last(mode_i);
  assign bit_o = bit_q;

  // Bits above the tap fall off the top as the word shifts left.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= '0;
      bit_q  <= 1'b0;
    end else begin
      if (load_i) begin
        data_q <= data_i;
      end else if (shift_i) begin
        data_q <= {data_q[MAX_BITS-2:0], 1'b0};
      end
      bit_q <= shift_i ? data_q[tap] : 1'b0;
    end
  end

endmodule

// File: rtl/ecc_serial_host.sv
// Host end of the ECC bit-serial link: serializes one job, deserializes the result.
// Optional WAIT timeout enabled by defining ECC_HOST_TIMEOUT_EN.
module ecc_serial_host
  import ecc_serial_host_pkg::*;
#(
  parameter int unsigned MAX_BITS = MAX_BITS_DEFAULT
`ifdef ECC_HOST_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_CYCLES = 65535
`endif
) (
  input  logic               clk,
  input  logic               rst,
  ecc_serial_host_if.slave   bus
);

  state_e              state_q;
  logic [1:0]          mode_q;
  logic [6:0]          cnt_q;
  logic                s_dv_q;
  logic                s_mode_q;
  logic [MAX_BITS-1:0] rx_x_q;
  logic [MAX_BITS-1:0] rx_y_q;
  logic                res_valid_q;
  logic                res_err_q;
  logic [6:0]          last;
  logic                load;
  logic                shift_en;
  logic [4:0]          s_bits;
  logic [4:0][MAX_BITS-1:0] ops;

`ifdef ECC_HOST_TIMEOUT_EN
  logic [31:0] tmo_q;
  logic [31:0] tmo_d;
  assign tmo_d = tmo_q + 32'd1;
`endif

  assign last = mode_last(mode_q);
  assign load = (state_q == ST_IDLE) && bus.cmd_valid;
  // Shifting starts on the second MODE cycle so bit N-1 appears on the first SEND cycle.
  assign shift_en = ((state_q == ST_MODE) && (cnt_q == 7'd1)) ||
                    ((state_q == ST_SEND) && (cnt_q != 7'd0));
  assign ops = {bus.cmd_mul, bus.cmd_py, bus.cmd_px, bus.cmd_prime, bus.cmd_a};

  for (genvar g = 0; g < 5; g++) begin : g_piso
    ecc_piso_shreg #(.MAX_BITS(MAX_BITS)) u_piso (
      .clk     (clk),
      .rst     (rst),
      .load_i  (load),
      .shift_i (shift_en),
      .mode_i  (mode_q),
      .data_i  (ops[g]),
      .bit_o   (s_bits[g])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      mode_q      <= 2'b00;
      cnt_q       <= 7'd0;
      s_dv_q      <= 1'b0;
      s_mode_q    <= 1'b0;
      rx_x_q      <= '0;
      rx_y_q      <= '0;
      res_valid_q <= 1'b0;
      res_err_q   <= 1'b0;
`ifdef ECC_HOST_TIMEOUT_EN
      tmo_q       <= 32'd0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.cmd_valid) begin
            mode_q  <= bus.cmd_mode;
            s_dv_q  <= 1'b1;
            rx_x_q  <= '0;
            rx_y_q  <= '0;
            state_q <= ST_START;
          end
        end
        ST_START: begin
          s_dv_q   <= 1'b0;
          s_mode_q <= mode_q[1];
          cnt_q    <= 7'd0;
          state_q  <= ST_MODE;
        end
        ST_MODE: begin
          if (cnt_q == 7'd0) begin
            s_mode_q <= mode_q[0];
            cnt_q    <= 7'd1;
          end else begin
            s_mode_q <= 1'b0;
            cnt_q    <= last;
            state_q  <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (cnt_q == 7'd0) begin
            state_q <= ST_WAIT;
`ifdef ECC_HOST_TIMEOUT_EN
            tmo_q   <= 32'd0;
`endif
          end else begin
            cnt_q <= cnt_q - 7'd1;
          end
        end
        ST_WAIT: begin
          if (bus.s_res_valid) begin
            rx_x_q  <= {rx_x_q[MAX_BITS-2:0], bus.s_res_x};
            rx_y_q  <= {rx_y_q[MAX_BITS-2:0], bus.s_res_y};
            cnt_q   <= last;
            state_q <= ST_RECV;
          end
`ifdef ECC_HOST_TIMEOUT_EN
          else if (tmo_d == TIMEOUT_CYCLES) begin
            rx_x_q      <= '0;
            rx_y_q      <= '0;
            res_valid_q <= 1'b1;
            res_err_q   <= 1'b1;
            state_q     <= ST_DONE;
          end else begin
            tmo_q <= tmo_d;
          end
`endif
        end
        ST_RECV: begin
          // cnt_q holds the number of bits still expected.
          if (bus.s_res_valid) begin
            rx_x_q <= {rx_x_q[MAX_BITS-2:0], bus.s_res_x};
            rx_y_q <= {rx_y_q[MAX_BITS-2:0], bus.s_res_y};
            if (cnt_q == 7'd1) begin
              res_valid_q <= 1'b1;
              state_q     <= ST_DONE;
            end else begin
              cnt_q <= cnt_q - 7'd1;
            end
          end else begin
            rx_x_q      <= '0;
            rx_y_q      <= '0;
            res_valid_q <= 1'b1;
            res_err_q   <= 1'b1;
            state_q     <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (bus.res_ready) begin
            res_valid_q <= 1'b0;
            res_err_q   <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.cmd_ready    = (state_q == ST_IDLE);
  assign bus.busy         = (state_q != ST_IDLE);
  assign bus.s_data_valid = s_dv_q;
  assign bus.s_mode       = s_mode_q;
  assign bus.s_a          = s_bits[0];
  assign bus.s_prime      = s_bits[1];
  assign bus.s_px         = s_bits[2];
  assign bus.s_py         = s_bits[3];
  assign bus.s_mul        = s_bits[4];
  assign bus.res_valid    = res_valid_q;
  assign bus.res_err      = res_err_q;
  assign bus.res_x        = rx_x_q;
  assign bus.res_y        = rx_y_q;

endmodule

// File: tb/tb_ecc_serial_host.sv
// Self-checking bench for ecc_serial_host: random jobs against a stream-level model.
// The timeout scenario runs only when ECC_HOST_TIMEOUT_EN is defined.
module tb_ecc_serial_host;

  localparam int MB = 128;
`ifdef ECC_HOST_TIMEOUT_EN
  localparam int TMO = 20;
`endif

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   passes = 0;

  ecc_serial_host_if #(.MAX_BITS(MB)) bus ();

  ecc_serial_host #(
    .MAX_BITS(MB)
`ifdef ECC_HOST_TIMEOUT_EN
    , .TIMEOUT_CYCLES(TMO)
`endif
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Expected {s_data_valid, s_mode, s_a, s_prime, s_px, s_py, s_mul} d cycles after accept.
  function automatic logic [6:0] tx_model(input int d, input logic [1:0] m,
                                          input logic [127:0] a, pr, px, py, mul);
    int n;
    int idx;
    logic [6:0] v;
    n = 16 << m;
    v = '0;
    if (d == 1) v[6] = 1'b1;
    if (d == 2) v[5] = m[1];
    if (d == 3) v[5] = m[0];
    if (d >= 4 && d < 4 + n) begin
      idx = n - 1 - (d - 4);
      v[4:0] = {a[idx], pr[idx], px[idx], py[idx], mul[idx]};
    end
    return v;
  endfunction

  // Offers a job and checks every serial output through the first WAIT cycle.
  task automatic run_transmit(input logic [1:0] m, input logic [127:0] a, pr, px, py, mul);
    int n;
    int budget;
    logic [6:0] act;
    logic [6:0] exp;
    n = 16 << m;
    budget = 0;
    while (bus.cmd_ready !== 1'b1 && budget < 100) begin
      cycle();
      budget++;
    end
    checks++;
    if (bus.cmd_ready !== 1'b1) $display("[TB] FAIL cmd_ready_wait: got %b want 1", bus.cmd_ready);
    else passes++;
    bus.cmd_mode = m; bus.cmd_a = a; bus.cmd_prime = pr;
    bus.cmd_px = px; bus.cmd_py = py; bus.cmd_mul = mul;
    bus.cmd_valid = 1'b1;
    cycle();
    bus.cmd_valid = 1'b0;
    checks++;
    if ({bus.busy, bus.cmd_ready} !== 2'b10)
      $display("[TB] FAIL busy_after_accept: got busy/ready=%b want 10", {bus.busy, bus.cmd_ready});
    else passes++;
    for (int d = 1; d <= n + 4; d++) begin
      exp = tx_model(d, m, a, pr, px, py, mul);
      act = {bus.s_data_valid, bus.s_mode, bus.s_a, bus.s_prime, bus.s_px, bus.s_py, bus.s_mul};
      checks++;
      if (act !== exp) $display("[TB] FAIL tx_slot T+%0d mode %0d: got %b want %b", d, m, act, exp);
      else passes++;
      if (d < n + 4) cycle();
    end
  endtask

  // Drives a result frame of count bits after gap idle cycles; builds expectations.
  task automatic drive_frame(input int n, input int count, input int gap,
                             input logic [127:0] xv, yv,
                             output logic [127:0] ex, output logic [127:0] ey, output logic eerr);
    logic xb;
    logic yb;
    for (int g = 0; g < gap; g++) begin
      bus.s_res_valid = 1'b0;
      bus.s_res_x = 1'($urandom());
      bus.s_res_y = 1'($urandom());
      cycle();
    end
    ex = '0;
    ey = '0;
    for (int k = 0; k < count; k++) begin
      xb = (k < n) ? xv[n-1-k] : 1'($urandom());
      yb = (k < n) ? yv[n-1-k] : 1'($urandom());
      if (k < n) begin
        ex = {ex[126:0], xb};
        ey = {ey[126:0], yb};
      end
      bus.s_res_valid = 1'b1;
      bus.s_res_x = xb;
      bus.s_res_y = yb;
      cycle();
      checks++;
      if (bus.res_valid !== ((k + 1 >= n) ? 1'b1 : 1'b0))
        $display("[TB] FAIL rx_valid_timing bit %0d of %0d: got %b", k, n, bus.res_valid);
      else passes++;
    end
    bus.s_res_valid = 1'b0;
    bus.s_res_x = 1'b0;
    bus.s_res_y = 1'b0;
    eerr = 1'b0;
    if (count < n) begin
      ex = '0;
      ey = '0;
      eerr = 1'b1;
      cycle();
      checks++;
      if (bus.res_valid !== 1'b1) $display("[TB] FAIL trunc_valid: got %b want 1", bus.res_valid);
      else passes++;
    end
  endtask

  task automatic finish_result(input logic [127:0] ex, ey, input logic eerr);
    checks++;
    if ({bus.res_valid, bus.busy, bus.res_err} !== {2'b11, eerr})
      $display("[TB] FAIL result_flags: got valid/busy/err=%b want %b",
               {bus.res_valid, bus.busy, bus.res_err}, {2'b11, eerr});
    else passes++;
    checks++;
    if (bus.res_x !== ex) $display("[TB] FAIL res_x: got %h want %h", bus.res_x, ex);
    else passes++;
    checks++;
    if (bus.res_y !== ey) $display("[TB] FAIL res_y: got %h want %h", bus.res_y, ey);
    else passes++;
    bus.res_ready = 1'b1;
    cycle();
    bus.res_ready = 1'b0;
    checks++;
    if ({bus.res_valid, bus.res_err, bus.cmd_ready} !== 3'b001)
      $display("[TB] FAIL result_release: got valid/err/ready=%b want 001",
               {bus.res_valid, bus.res_err, bus.cmd_ready});
    else passes++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.cmd_valid = 1'b0; bus.cmd_mode = 2'b00;
    bus.cmd_a = '0; bus.cmd_prime = '0; bus.cmd_px = '0; bus.cmd_py = '0; bus.cmd_mul = '0;
    bus.res_ready = 1'b0; bus.s_res_valid = 1'b0; bus.s_res_x = 1'b0; bus.s_res_y = 1'b0;
    #2;
    checks++;
    if ({bus.busy, bus.res_valid, bus.res_err, bus.s_data_valid, bus.s_mode, bus.s_a,
         bus.s_prime, bus.s_px, bus.s_py, bus.s_mul, bus.cmd_ready} !== 11'b00000000001)
      $display("[TB] FAIL reset_flags: got %b want 00000000001",
               {bus.busy, bus.res_valid, bus.res_err, bus.s_data_valid, bus.s_mode, bus.s_a,
                bus.s_prime, bus.s_px, bus.s_py, bus.s_mul, bus.cmd_ready});
    else passes++;
    checks++;
    if ({bus.res_x, bus.res_y} !== 256'd0) $display("[TB] FAIL reset_result: got %h want 0", {bus.res_x, bus.res_y});
    else passes++;
    cycle();
    cycle();
    rst = 1'b0;
    // Serial result traffic while idle must do nothing.
    for (int i = 0; i < 5; i++) begin
      bus.s_res_valid = 1'b1;
      bus.s_res_x = 1'b1;
      bus.s_res_y = 1'($urandom());
      cycle();
    end
    bus.s_res_valid = 1'b0;
    checks++;
    if ({bus.res_valid, bus.busy, bus.cmd_ready, bus.res_x} !== {3'b001, 128'd0})
      $display("[TB] FAIL idle_ignores_rx: got valid/busy/ready=%b res_x=%h",
               {bus.res_valid, bus.busy, bus.cmd_ready}, bus.res_x);
    else passes++;
  endtask

  task automatic test_mode16();
    logic [127:0] px;
    logic [127:0] ex;
    logic [127:0] ey;
    logic eerr;
    px = rand128();
    px[15:0] = 16'h1234;
    run_transmit(2'b00, '0, '0, px, '0, '0);
    drive_frame(16, 16, 0, rand128(), rand128(), ex, ey, eerr);
    finish_result(ex, ey, eerr);
  endtask

  task automatic test_mode128();
    logic [127:0] mul;
    logic [127:0] ex;
    logic [127:0] ey;
    logic eerr;
    mul = '0;
    mul[127] = 1'b1;
    run_transmit(2'b11, '0, '0, '0, '0, mul);
    drive_frame(128, 128, 3, {16{8'hA5}}, rand128(), ex, ey, eerr);
    checks++;
    if (ex !== {16{8'hA5}}) $display("[TB] FAIL a5_model: got %h want %h", ex, {16{8'hA5}});
    else passes++;
    finish_result(ex, ey, eerr);
  endtask

  task automatic test_backpressure();
    logic [127:0] ex;
    logic [127:0] ey;
    logic [127:0] ex2;
    logic [127:0] ey2;
    logic eerr;
    logic [127:0] a2;
    logic [127:0] mul2;
    run_transmit(2'b01, rand128(), rand128(), rand128(), rand128(), rand128());
    drive_frame(32, 32, 2, rand128(), rand128(), ex, ey, eerr);
    a2 = rand128();
    mul2 = rand128();
    bus.cmd_mode = 2'b01; bus.cmd_a = a2; bus.cmd_mul = mul2; bus.cmd_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bus.s_res_valid = 1'b1;
      bus.s_res_x = 1'($urandom());
      bus.s_res_y = 1'($urandom());
      checks++;
      if ({bus.res_valid, bus.cmd_ready, bus.busy} !== 3'b101 || bus.res_x !== ex || bus.res_y !== ey)
        $display("[TB] FAIL hold_stable cycle %0d: got valid/ready/busy=%b x=%h want x=%h", i,
                 {bus.res_valid, bus.cmd_ready, bus.busy}, bus.res_x, ex);
      else passes++;
      cycle();
    end
    bus.cmd_valid = 1'b0;
    bus.s_res_valid = 1'b0;
    finish_result(ex, ey, eerr);
    run_transmit(2'b01, a2, '0, '0, '0, mul2);
    drive_frame(32, 32, 1, rand128(), rand128(), ex2, ey2, eerr);
    finish_result(ex2, ey2, eerr);
  endtask

  task automatic test_truncated();
    logic [127:0] ex;
    logic [127:0] ey;
    logic eerr;
    run_transmit(2'b10, rand128(), rand128(), rand128(), rand128(), rand128());
    drive_frame(64, 40, 4, rand128(), rand128(), ex, ey, eerr);
    finish_result(ex, ey, eerr);
  endtask

  task automatic test_reset_mid_send();
    logic [127:0] ex;
    logic [127:0] ey;
    logic eerr;
    bus.cmd_mode = 2'b01;
    bus.cmd_a = '1; bus.cmd_prime = '1; bus.cmd_px = '1; bus.cmd_py = '1; bus.cmd_mul = '1;
    bus.cmd_valid = 1'b1;
    cycle();
    bus.cmd_valid = 1'b0;
    repeat (12) cycle();
    rst = 1'b1;
    #2;
    checks++;
    if ({bus.s_data_valid, bus.s_mode, bus.s_a, bus.s_prime, bus.s_px, bus.s_py, bus.s_mul,
         bus.busy, bus.cmd_ready} !== 9'b000000001)
      $display("[TB] FAIL reset_mid_send: got %b want 000000001",
               {bus.s_data_valid, bus.s_mode, bus.s_a, bus.s_prime, bus.s_px, bus.s_py, bus.s_mul,
                bus.busy, bus.cmd_ready});
    else passes++;
    cycle();
    rst = 1'b0;
    cycle();
    run_transmit(2'b01, rand128(), rand128(), rand128(), rand128(), rand128());
    drive_frame(32, 32, 0, rand128(), rand128(), ex, ey, eerr);
    finish_result(ex, ey, eerr);
  endtask

  task automatic test_random();
    logic [1:0] m;
    int n;
    int count;
    int sel;
    logic [127:0] ex;
    logic [127:0] ey;
    logic eerr;
    for (int j = 0; j < 6; j++) begin
      m = 2'($urandom_range(0, 3));
      n = 16 << m;
      sel = $urandom_range(0, 2);
      count = (sel == 0) ? n : (sel == 1) ? $urandom_range(1, n - 1) : n + $urandom_range(1, 8);
      run_transmit(m, rand128(), rand128(), rand128(), rand128(), rand128());
      drive_frame(n, count, $urandom_range(0, 5), rand128(), rand128(), ex, ey, eerr);
      finish_result(ex, ey, eerr);
    end
  endtask

`ifdef ECC_HOST_TIMEOUT_EN
  task automatic test_timeout();
    run_transmit(2'b00, rand128(), rand128(), rand128(), rand128(), rand128());
    for (int k = 1; k <= TMO; k++) begin
      cycle();
      checks++;
      if (bus.res_valid !== ((k == TMO) ? 1'b1 : 1'b0))
        $display("[TB] FAIL timeout_timing wait %0d: got %b", k, bus.res_valid);
      else passes++;
    end
    for (int i = 0; i < 16; i++) begin
      bus.s_res_valid = 1'b1;
      bus.s_res_x = 1'b1;
      bus.s_res_y = 1'b1;
      cycle();
    end
    bus.s_res_valid = 1'b0;
    finish_result('0, '0, 1'b1);
  endtask
`endif

  initial begin
    test_reset();
    test_mode16();
    test_mode128();
    test_backpressure();
    test_truncated();
    test_reset_mid_send();
    test_random();
`ifdef ECC_HOST_TIMEOUT_EN
    test_timeout();
`endif
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/ecc_serial_host.md
Name: ecc_serial_host

Overview:
- Host-side end of the ECC core's bit-serial link.
- Accepts one parallel scalar-multiply job: mode, a, prime, Px, Py and multiplier.
- Transmits the job MSB-first to the serial ECC wrapper, then deserializes the returned result point (x, y) into parallel words.
- Sits between a bus-side command/result interface and the wrapper's serial pins; used by the top-level testbench and by the SoC integration.

Parameters:
- MAX_BITS, 128, width of parallel operand and result words; must be ≥ 128.
- TIMEOUT_CYCLES, 65535, maximum WAIT cycles before a timeout. Used only with ECC_HOST_TIMEOUT_EN.

Ports:
- clk  in  1  system clock, all logic on the rising edge
- rst  in  1  asynchronous, active-high reset
- cmd_valid  in  1  job offered
- cmd_ready  out  1  high only in IDLE
- cmd_mode  in  2  00=16b, 01=32b, 10=64b, 11=128b
- cmd_a, cmd_prime, cmd_px, cmd_py, cmd_mul  in  MAX_BITS each  operands, right-aligned
- res_valid  out  1  result held until accepted
- res_ready  in  1  result consumer ready
- res_x, res_y  out  MAX_BITS each  result, right-aligned, upper bits zero
- res_err  out  1  qualifies res_valid: frame was truncated or timed out
- busy  out  1  high whenever state is not IDLE
- s_data_valid  out  1  frame-start pulse to the wrapper
- s_mode  out  1  serial mode bit
- s_a, s_prime, s_px, s_py, s_mul  out  1 each  serial operand bits
- s_res_valid  in  1  wrapper output-valid
- s_res_x, s_res_y  in  1 each  serial result bits

Behaviour:
- Reset (asynchronous, immediate):
  - state=IDLE, all counters 0.
  - All s_* outputs, res_valid, res_err, res_x, res_y and busy are 0; cmd_ready=1.
  - Reset mid-frame aborts the frame; the wrapper must be reset alongside.
- Width rule: N = 16 << mode, latched at command accept. Bit N-1 is sent first; bits ≥ N are ignored.
- Transmit latency, with the accept edge at cycle T (cmd_valid & cmd_ready):
  - T+1: s_data_valid=1, all data lines 0.
  - T+2: s_mode = mode[1].
  - T+3: s_mode = mode[0].
  - T+4 .. T+3+N: operand bit N-1-k on s_a, s_prime, s_px, s_py, s_mul simultaneously, for k = 0..N-1.
  - s_data_valid and s_mode are 0 outside their slots; data lines are 0 outside the data window.
- States:
  - IDLE: on accept, latch all operands into shift registers and latch the mode; go to START.
  - START: one cycle; go to MODE.
  - MODE: two cycles; go to SEND.
  - SEND: N cycles, down-counter N-1..0, shift left each cycle; go to WAIT.
  - WAIT: hold all s_* at 0.
    - s_res_valid=1: capture the current s_res_x/s_res_y bit as MSB, cnt=N-1, go to RECV.
  - RECV: while s_res_valid=1, shift in s_res_x/s_res_y.
    - After N total bits: go to DONE, res_err=0.
    - If s_res_valid=0 before N bits: go to DONE with res_err=1 and res_x=res_y=0.
  - DONE: res_valid=1; outputs stable until res_ready=1.
    - res_valid & res_ready: go to IDLE, clear res_valid and res_err.
- res_valid rises the cycle after the last serial bit is captured.
- s_res_valid outside WAIT/RECV is ignored and has no side effects.
- cmd_valid while busy is not accepted; no buffering, a single job in flight.
- s_res_valid already high on the first WAIT cycle (zero gap) is captured normally.
- A received frame longer than N bits: the extra bits are ignored once in DONE.

Optional Feature:
- Macro: ECC_HOST_TIMEOUT_EN.
- Defined:
  - A 32-bit counter runs in WAIT and resets on WAIT entry.
  - When it reaches TIMEOUT_CYCLES: go to DONE with res_err=1 and res_x=res_y=0.
  - A late frame arriving after timeout is ignored per the rule above.
- Undefined: WAIT has no bound and the counter logic is absent. res_err reports truncation only.

Decomposition:
- Shared package/header:
  - Mode encodings BITS16/32/64/128 (same values as the wrapper).
  - Helper mapping mode to N-1.
  - State encodings.
  - MAX_BITS default.
- Sub-module: ecc_piso_shreg, a loadable MSB-first parallel-in/serial-out shift register with a mode-selected tap. It is instantiated five times for the operands; its SIPO counterpart is an inline shift.

Test Plan:
- Mode 00, px=0x1234, others 0, accepted at T → s_px = 0001 0010 0011 0100 on T+4..T+19; s_data_valid only at T+1; s_mode 0,0 at T+2..T+3.
- Mode 11, mul=1<<127 → s_mul=1 only at T+4. Then drive s_res_valid for 128 cycles with x=0xA5 repeating → res_x matches; res_valid the cycle after the last bit; res_err=0.
- Mode 01: hold res_ready=0 for 10 cycles after res_valid → res_x/res_y stable, cmd_ready=0. Offer a second cmd_valid meanwhile → not accepted until the handshake completes.
- Mode 10: s_res_valid drops after 40 of 64 bits → res_valid=1, res_err=1, res_x=res_y=0.
- Assert rst during SEND in mode 01 → s_* outputs 0 in the same cycle, cmd_ready=1; a new job after release transmits correctly.
- With ECC_HOST_TIMEOUT_EN and TIMEOUT_CYCLES=20: no response → res_err=1 after 20 WAIT cycles. A later s_res_valid burst is ignored.
